// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Also produces leading-zero blank flags and an overflow flag for the 7-segment display stage.
module binary_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               sticky_q, sticky_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adjusted;
  logic [DIGITS-1:0]  blankCalc;

  // Add-3 correction on every digit, taken from the pre-shift scratch value
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    blankCalc = '0;
    for (int i = 1; i < DIGITS; i++) begin
      logic allZero;
      allZero = 1'b1;
      for (int j = i; j < DIGITS; j++) begin
        if (scratch_q[4*j +: 4] != 4'd0) allZero = 1'b0;
      end
      blankCalc[i] = allZero;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    sticky_d  = sticky_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Bit shifted out of the top digit means the value no longer fits
        scratch_d = {adjusted[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d     = {bin_q[BIN_W-2:0], 1'b0};
        sticky_d  = sticky_q | adjusted[BCD_W-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = scratch_q;
        blank_d = blankCalc;
        ovf_d   = sticky_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign blank    = blank_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq: expected results are queued at accepted starts
// and a monitor pops them whenever done pulses; a second 4-digit instance exercises overflow.
module tb_binary_to_bcd_seq;

  localparam int BIN_W = 16;
  localparam int LAT   = BIN_W + 1;

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;
    int          doneCyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] binIn;
  logic        busy, done, overflow;
  logic [19:0] bcdOut;
  logic [4:0]  blank;

  logic        start4;
  logic [15:0] bin4;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic [3:0]  blank4;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lastStart = -100;
  exp_t expQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(binIn), .busy(busy), .done(done),
    .bcd_out(bcdOut), .blank(blank), .overflow(overflow)
  );

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin_in(bin4), .busy(busy4), .done(done4),
    .bcd_out(bcd4), .blank(blank4), .overflow(ovf4)
  );

  // Reference: plain decimal arithmetic on the value, reduced modulo 10^digits
  function automatic exp_t model(input int v, input int digits);
    exp_t e;
    longint pow, m, p;
    pow = 1;
    for (int i = 0; i < digits; i++) pow = pow * 10;
    e.ovf = (v >= pow);
    m = v % pow;
    e.bcd = '0;
    e.blank = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'((m / p) % 10);
      if (i > 0) e.blank[i] = ((m / p) == 0);
      p = p * 10;
    end
    e.doneCyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("bcd_out", 32'(bcdOut), 32'(e.bcd));
        checkOutput("blank", 32'(blank), 32'(e.blank));
        checkOutput("overflow", 32'(overflow), 32'(e.ovf));
        checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput("busy", 32'(busy), 32'((cyc >= lastStart) && (cyc < lastStart + LAT)));
  endtask

  task automatic applyStimulus(input int v);
    start = 1'b1;
    binIn = 16'(v);
    @(posedge clk);
    #1;
    if (cyc >= lastStart + LAT + 1) begin
      exp_t e;
      e = model(v, 5);
      e.doneCyc = cyc + LAT;
      expQ.push_back(e);
      lastStart = cyc;
    end
    start = 1'b0;
    binIn = 16'($urandom);
    checkOutput("busy", 32'(busy), 32'((cyc >= lastStart) && (cyc < lastStart + LAT)));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_bcd"}, 32'(bcdOut), 32'd0);
    checkOutput({tag, "_blank"}, 32'(blank), 32'b11110);
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic waitDrain();
    int budget;
    budget = 4 * LAT;
    while (expQ.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0 pending", expQ.size());
      expQ.delete();
    end
    tick();
  endtask

  task automatic runSmall(input int v);
    exp_t e;
    int budget;
    e = model(v, 4);
    start4 = 1'b1;
    bin4 = 16'(v);
    @(posedge clk);
    #1;
    start4 = 1'b0;
    bin4 = 16'($urandom);
    budget = 3 * LAT;
    while (!done4 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checkOutput("d4_done_seen", 32'(done4), 32'd1);
    checkOutput("d4_bcd", 32'(bcd4), 32'(e.bcd[15:0]));
    checkOutput("d4_blank", 32'(blank4), 32'(e.blank[3:0]));
    checkOutput("d4_ovf", 32'(ovf4), 32'(e.ovf));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int boundary[8];
    rst = 1'b1;
    start = 1'b1;
    binIn = 16'd123;
    start4 = 1'b0;
    bin4 = '0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b0;
    checkResetValues("reset");
    checkOutput("reset_busy", 32'(busy), 32'd0);

    applyStimulus(0);
    waitDrain();
    applyStimulus(65535);
    waitDrain();

    applyStimulus(1234);
    repeat (4) tick();
    applyStimulus(999);
    waitDrain();

    applyStimulus(42);
    for (int i = 0; i < 3 * LAT && !done; i++) tick();
    applyStimulus(7);
    waitDrain();

    applyStimulus(500);
    repeat (7) tick();
    rst = 1'b1;
    lastStart = -100;
    expQ.delete();
    tick();
    rst = 1'b0;
    checkResetValues("abort");
    repeat (2 * LAT) tick();
    applyStimulus(500);
    waitDrain();
    repeat (5) tick();
    checkOutput("hold_bcd", 32'(bcdOut), 32'h00500);
    checkOutput("hold_blank", 32'(blank), 32'b11000);

    boundary = '{9, 10, 99, 100, 999, 9999, 10000, 65534};
    foreach (boundary[i]) begin
      applyStimulus(boundary[i]);
      waitDrain();
    end

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 20)) tick();
      applyStimulus(int'($urandom_range(0, 65535)));
    end
    waitDrain();

    runSmall(10000);
    runSmall(9999);
    runSmall(65535);
    runSmall(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
